npuarc_to_sched: RTL and testbench

- Scheduler/controller for a bank of NUM_CH timeout monitor instances, one per outstanding-transaction channel.
- Generates the shared prescaled tick that drives each monitor's clock enable.
- Sequences each monitor's to_start/to_end levels so that every edge is sampled on a tick.
- Collects timeout flags into sticky, software-clearable error status with a first-error record and an interrupt.

---
 rtl/npuarc_to_sched_pkg.sv | 24 ++
 rtl/npuarc_to_sched_ch.sv | 74 +++++++
 rtl/npuarc_to_sched.sv | 118 +++++++++++
 tb/tb_npuarc_to_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/npuarc_to_sched_pkg.sv
// Shared definitions for the timeout-monitor scheduler.
//   ch_state_e : per-channel sequencing state (IDLE/ACTIVE/TIMEOUT/CLOSE)
//   MAX_CH     : upper bound on channel count, sizes the priority encoder
//   lowest_set : index of the lowest set bit, used for first-error capture
package npuarc_to_sched_pkg;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_ACTIVE  = 2'd1,
    CH_TIMEOUT = 2'd2,
    CH_CLOSE   = 2'd3
  } ch_state_e;

  localparam int unsigned MAX_CH = 16;

  // Scan from the top down so the lowest set index is the last write.
  function automatic logic [3:0] lowest_set(input logic [MAX_CH-1:0] vec);
    lowest_set = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set = 4'(i);
    end
  endfunction

endpackage

// File: rtl/npuarc_to_sched_ch.sv
// Per-channel sequencer for one timeout monitor.
// Ports:
//   clk, rst_a              : clock, async active-high reset
//   cfg_en_i                : scheduler enable
//   tick_i                  : shared monitor clock enable (registered tick)
//   req_valid_i/req_done_i  : transaction issued / completed pulses
//   err_clr_i               : W1C pulse for this channel's error
//   to_flag_i               : timeout flag from the monitor
//   to_start_o/to_end_o     : registered monitor start/end levels
//   err_o                   : registered sticky error (channel in TIMEOUT)
//   err_d_o                 : next-cycle value of err_o, for first-error capture
//   state_o                 : current state, exposed for debug/checkers
// Interface semantics: all request inputs are single-cycle pulses sampled on
// every clk edge; there is no back-pressure, so a pulse the current state does
// not accept is dropped.
module npuarc_to_sched_ch
  import npuarc_to_sched_pkg::*;
(
  input  logic      clk,
  input  logic      rst_a,
  input  logic      cfg_en_i,
  input  logic      tick_i,
  input  logic      req_valid_i,
  input  logic      req_done_i,
  input  logic      err_clr_i,
  input  logic      to_flag_i,
  output logic      to_start_o,
  output logic      to_end_o,
  output logic      err_o,
  output logic      err_d_o,
  output ch_state_e state_o
);

  ch_state_e state_q, state_d;
  logic      start_q, end_q, err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      CH_IDLE:    if (req_valid_i && cfg_en_i) state_d = CH_ACTIVE;
      // Completion beats a coincident timeout flag.
      CH_ACTIVE: begin
        if (req_done_i)      state_d = CH_CLOSE;
        else if (to_flag_i)  state_d = CH_TIMEOUT;
        else if (!cfg_en_i)  state_d = CH_CLOSE;
      end
      CH_TIMEOUT: if (err_clr_i) state_d = CH_CLOSE;
      // Hold end high until a tick so the monitor actually samples it.
      CH_CLOSE:   if (tick_i) state_d = CH_IDLE;
      default:    state_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state_q <= CH_IDLE;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= (state_d == CH_ACTIVE) || (state_d == CH_TIMEOUT);
      end_q   <= (state_d == CH_CLOSE);
      err_q   <= (state_d == CH_TIMEOUT);
    end
  end

  assign to_start_o = start_q;
  assign to_end_o   = end_q;
  assign err_o      = err_q;
  assign err_d_o    = (state_d == CH_TIMEOUT);
  assign state_o    = state_q;

endmodule

// File: rtl/npuarc_to_sched.sv
// Scheduler for a bank of NUM_CH timeout monitors: shared prescaled tick,
// per-channel start/end sequencing, sticky error status with first-error
// record and level interrupt.
// Ports:
//   clk, rst_a        : clock, async active-high reset
//   cfg_en            : scheduler enable (0 = tick every cycle, channels close)
//   cfg_prescale      : tick period minus 1
//   req_valid/req_done/err_clr : per-channel pulses
//   to_flag_i         : per-channel monitor timeout flags
//   tick_o            : registered clock enable to all monitors
//   to_start_o/to_end_o : per-channel monitor levels
//   err_status        : sticky per-channel timeout status
//   err_first_vld/err_first_id : first-error record
//   err_irq           : OR of err_status
module npuarc_to_sched
  import npuarc_to_sched_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int PRESCALE_W = 8,
  parameter int ID_W       = 2
) (
  input  logic                  clk,
  input  logic                  rst_a,
  input  logic                  cfg_en,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic [NUM_CH-1:0]     req_valid,
  input  logic [NUM_CH-1:0]     req_done,
  input  logic [NUM_CH-1:0]     err_clr,
  input  logic [NUM_CH-1:0]     to_flag_i,
  output logic                  tick_o,
  output logic [NUM_CH-1:0]     to_start_o,
  output logic [NUM_CH-1:0]     to_end_o,
  output logic [NUM_CH-1:0]     err_status,
  output logic                  err_first_vld,
  output logic [ID_W-1:0]       err_first_id,
  output logic                  err_irq
);

  // Prescaler. The compare is >= so lowering cfg_prescale below the running
  // count produces a tick on the next cycle instead of a full wrap.
  logic [PRESCALE_W-1:0] count_q, count_d;
  logic                  tick_q, tick_d;

  always_comb begin
    tick_d  = 1'b1;
    count_d = '0;
    if (cfg_en && (count_q < cfg_prescale)) begin
      tick_d  = 1'b0;
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick_o = tick_q;

  // Channel bank.
  logic [NUM_CH-1:0] err_next;
  ch_state_e         ch_state [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    npuarc_to_sched_ch u_ch (
      .clk         (clk),
      .rst_a       (rst_a),
      .cfg_en_i    (cfg_en),
      .tick_i      (tick_q),
      .req_valid_i (req_valid[g]),
      .req_done_i  (req_done[g]),
      .err_clr_i   (err_clr[g]),
      .to_flag_i   (to_flag_i[g]),
      .to_start_o  (to_start_o[g]),
      .to_end_o    (to_end_o[g]),
      .err_o       (err_status[g]),
      .err_d_o     (err_next[g]),
      .state_o     (ch_state[g])
    );
  end

  // First-error record. Captured from the next-cycle status so the record
  // appears together with err_status. Clearing the recorded channel drops
  // valid for one cycle; any other pending error is then re-captured.
  logic            first_vld_q, first_vld_d;
  logic [ID_W-1:0] first_id_q, first_id_d;

  always_comb begin
    first_vld_d = first_vld_q;
    first_id_d  = first_id_q;
    if (first_vld_q) begin
      if (err_clr[first_id_q] && err_status[first_id_q]) first_vld_d = 1'b0;
    end else if (|err_next) begin
      first_vld_d = 1'b1;
      first_id_d  = ID_W'(lowest_set(MAX_CH'(err_next)));
    end
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      first_vld_q <= 1'b0;
      first_id_q  <= '0;
    end else begin
      first_vld_q <= first_vld_d;
      first_id_q  <= first_id_d;
    end
  end

  assign err_first_vld = first_vld_q;
  assign err_first_id  = first_id_q;
  assign err_irq       = |err_status;

endmodule

// File: tb/tb_npuarc_to_sched.sv
module tb_npuarc_to_sched;

  localparam int NUM_CH = 4;
  localparam int PW     = 8;
  localparam int IW     = 2;
  localparam int W      = 1 + 3 * NUM_CH + 2 + IW;

  // Channel phases of the reference model.
  localparam int P_IDLE = 0, P_ACT = 1, P_TO = 2, P_CLOSE = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  always #5 clk = ~clk;

  logic              cfg_en = 1'b0;
  logic [PW-1:0]     cfg_prescale = '0;
  logic [NUM_CH-1:0] req_valid = '0, req_done = '0, err_clr = '0, to_flag_i = '0;
  logic              tick_o, err_first_vld, err_irq;
  logic [NUM_CH-1:0] to_start_o, to_end_o, err_status;
  logic [IW-1:0]     err_first_id;

  npuarc_to_sched #(.NUM_CH(NUM_CH), .PRESCALE_W(PW), .ID_W(IW)) dut (
    .clk           (clk),
    .rst_a         (rst_a),
    .cfg_en        (cfg_en),
    .cfg_prescale  (cfg_prescale),
    .req_valid     (req_valid),
    .req_done      (req_done),
    .err_clr       (err_clr),
    .to_flag_i     (to_flag_i),
    .tick_o        (tick_o),
    .to_start_o    (to_start_o),
    .to_end_o      (to_end_o),
    .err_status    (err_status),
    .err_first_vld (err_first_vld),
    .err_first_id  (err_first_id),
    .err_irq       (err_irq)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_cyc = 0;

  // ---------------- reference model ----------------
  int m_cnt;
  bit m_tick;
  int m_ph [NUM_CH];
  bit m_vld;
  int m_id;

  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] dut_vec();
    return {tick_o, to_start_o, to_end_o, err_status, err_irq, err_first_vld, err_first_id};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_tick = 0; m_vld = 0; m_id = 0;
    for (int i = 0; i < NUM_CH; i++) m_ph[i] = P_IDLE;
  endtask

  // Drive one cycle's inputs and push the outputs expected after the edge.
  task automatic apply(input logic en, input logic [PW-1:0] pre,
                       input logic [NUM_CH-1:0] rv, rd, ec, fl);
    int n_ph [NUM_CH];
    int n_cnt;
    bit n_tick;
    logic [NUM_CH-1:0] st, sa, en_v;
    logic [W-1:0] e;
    cfg_en = en; cfg_prescale = pre;
    req_valid = rv; req_done = rd; err_clr = ec; to_flag_i = fl;

    if (!en || m_cnt >= int'(pre)) begin n_tick = 1; n_cnt = 0; end
    else begin n_tick = 0; n_cnt = m_cnt + 1; end

    for (int i = 0; i < NUM_CH; i++) begin
      n_ph[i] = m_ph[i];
      if (m_ph[i] == P_IDLE && rv[i] && en) n_ph[i] = P_ACT;
      else if (m_ph[i] == P_ACT) begin
        if (rd[i])      n_ph[i] = P_CLOSE;
        else if (fl[i]) n_ph[i] = P_TO;
        else if (!en)   n_ph[i] = P_CLOSE;
      end
      else if (m_ph[i] == P_TO && ec[i]) n_ph[i] = P_CLOSE;
      else if (m_ph[i] == P_CLOSE && m_tick) n_ph[i] = P_IDLE;
    end

    for (int i = 0; i < NUM_CH; i++) begin
      st[i]   = (n_ph[i] == P_TO);
      sa[i]   = (n_ph[i] == P_ACT) || (n_ph[i] == P_TO);
      en_v[i] = (n_ph[i] == P_CLOSE);
    end

    if (m_vld) begin
      if (ec[m_id] && m_ph[m_id] == P_TO) m_vld = 0;
    end else if (st != 0) begin
      m_vld = 1;
      for (int i = NUM_CH - 1; i >= 0; i--) if (st[i]) m_id = i;
    end

    m_cnt = n_cnt; m_tick = n_tick;
    for (int i = 0; i < NUM_CH; i++) m_ph[i] = n_ph[i];
    e = {m_tick, sa, en_v, st, |st, m_vld, IW'(m_id)};
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic en, input logic [PW-1:0] pre,
                       input logic [NUM_CH-1:0] rv, rd, ec, fl);
    @(negedge clk);
    apply(en, pre, rv, rd, ec, fl);
  endtask

  task automatic idle(input int n, input logic en, input logic [PW-1:0] pre);
    for (int k = 0; k < n; k++) cycle(en, pre, '0, '0, '0, '0);
  endtask

  // Async reset between edges: outputs must drop at once.
  task automatic do_reset();
    logic [W-1:0] got;
    rst_a = 1'b1;
    #1;
    got = dut_vec();
    n_vec++;
    if (got !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h exp=%h", got, {W{1'b0}});
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    apply(1'b0, '0, '0, '0, '0, '0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = dut_vec();
        // err_first_id is only meaningful while err_first_vld is set.
        if (!e[IW]) begin
          e[IW-1:0] = '0;
          got[IW-1:0] = '0;
        end
        n_vec++;
        n_cyc++;
        if (got !== e) begin
          n_err++;
          $display("FAIL outputs@%0t got tick=%b st=%b end=%b err=%b irq=%b vld=%b id=%0d exp tick=%b st=%b end=%b err=%b irq=%b vld=%b id=%0d",
                   $time, got[W-1], got[W-2 -: 4], got[W-6 -: 4], got[W-10 -: 4], got[IW+1], got[IW], got[IW-1:0],
                   e[W-1], e[W-2 -: 4], e[W-6 -: 4], e[W-10 -: 4], e[IW+1], e[IW], e[IW-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic en_r;
    logic [PW-1:0] pre_r;
    #3;
    do_reset();

    // Prescale 3 then 0.
    idle(2, 1'b0, 8'd3);
    idle(13, 1'b1, 8'd3);
    idle(4, 1'b1, 8'd0);
    // Lowering prescale below the running count.
    idle(5, 1'b1, 8'd7);
    idle(3, 1'b1, 8'd1);

    // Normal completion on channel 1.
    idle(2, 1'b1, 8'd0);
    cycle(1'b1, 8'd0, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    idle(3, 1'b1, 8'd0);
    cycle(1'b1, 8'd0, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    idle(3, 1'b1, 8'd0);

    // Timeout on channel 2, ignored done, then clear.
    cycle(1'b1, 8'd0, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    idle(15, 1'b1, 8'd0);
    cycle(1'b1, 8'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    cycle(1'b1, 8'd0, 4'b0000, 4'b0100, 4'b0000, 4'b0100);
    cycle(1'b1, 8'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    cycle(1'b1, 8'd0, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    idle(3, 1'b1, 8'd0);

    // Simultaneous timeouts on 1 and 3; clear 1, then 3.
    cycle(1'b1, 8'd0, 4'b1010, 4'b0000, 4'b0000, 4'b0000);
    idle(2, 1'b1, 8'd0);
    cycle(1'b1, 8'd0, 4'b0000, 4'b0000, 4'b0000, 4'b1010);
    idle(2, 1'b1, 8'd0);
    cycle(1'b1, 8'd0, 4'b0000, 4'b0000, 4'b0011, 4'b1000);
    idle(3, 1'b1, 8'd0);
    cycle(1'b1, 8'd0, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    idle(3, 1'b1, 8'd0);

    // Done/flag collision on channel 0 and req_valid during CLOSE.
    cycle(1'b1, 8'd5, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    idle(2, 1'b1, 8'd5);
    cycle(1'b1, 8'd5, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
    cycle(1'b1, 8'd5, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
    idle(8, 1'b1, 8'd5);

    // Disable with channels 0 and 2 active.
    cycle(1'b1, 8'd2, 4'b0101, 4'b0000, 4'b0000, 4'b0000);
    idle(2, 1'b1, 8'd2);
    idle(3, 1'b0, 8'd2);
    cycle(1'b0, 8'd2, 4'b0101, 4'b0000, 4'b0000, 4'b0000);
    idle(2, 1'b1, 8'd2);

    // Randomized traffic.
    en_r = 1'b1;
    pre_r = 8'd1;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 29) == 0) pre_r = PW'($urandom_range(0, 5));
      if ($urandom_range(0, 24) == 0) en_r = ~en_r;
      else if (!en_r && $urandom_range(0, 2) == 0) en_r = 1'b1;
      cycle(en_r, pre_r,
            4'($urandom_range(0, 15) & $urandom_range(0, 15)),
            4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)),
            4'($urandom_range(0, 15) & $urandom_range(0, 15)),
            4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)));
    end

    // Reset in the middle of a timeout.
    idle(4, 1'b1, 8'd0);
    cycle(1'b1, 8'd0, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    idle(2, 1'b1, 8'd0);
    cycle(1'b1, 8'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    idle(2, 1'b1, 8'd0);
    @(posedge clk);
    #3;
    do_reset();
    idle(6, 1'b1, 8'd1);

    @(posedge clk);
    #3;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
